// File: rtl/button_event_arbiter_if.sv
// Event handshake between the button arbiter (master) and the app/UI consumer (slave).
interface button_event_arbiter_if #(
    parameter int IDX_W = 3
);
    logic             evt_valid;
    logic [IDX_W-1:0] evt_id;
    logic             evt_ack;

    modport master (
        output evt_valid,
        output evt_id,
        input  evt_ack
    );

    modport slave (
        input  evt_valid,
        input  evt_id,
        output evt_ack
    );
endinterface

// File: rtl/button_event_arbiter.sv
// Raw pushbuttons -> synchronised, debounced press events, queued per button and
// handed out one at a time in round-robin order over a valid/ack handshake.
module button_event_arbiter #(
    parameter int N_BTN           = 5,
    parameter int IDX_W           = 3,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_BTN-1:0]      btn_raw,
    button_event_arbiter_if.master evt,
    output logic [N_BTN-1:0]      btn_level,
    output logic [N_BTN-1:0]      pending,
    output logic [N_BTN-1:0]      overrun
);

    typedef enum logic {
        IDLE,
        OFFER
    } state_t;

    state_t           r_state;
    logic [N_BTN-1:0] r_sync1;
    logic [N_BTN-1:0] r_sync2;
    logic [CNT_W-1:0] r_cnt [N_BTN];
    logic [N_BTN-1:0] r_levelD;
    logic [N_BTN-1:0] r_press;
    logic             r_valid;
    logic [IDX_W-1:0] r_evtId;
    logic [IDX_W-1:0] r_lastGrant;

    logic [N_BTN-1:0] w_ackVec;
    logic             w_found;
    logic [IDX_W-1:0] w_nextId;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    // A level change is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_level <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                if (r_sync2[i] != btn_level[i]) begin
                    if (r_cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                        btn_level[i] <= r_sync2[i];
                        r_cnt[i]     <= '0;
                    end else begin
                        r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                    end
                end else begin
                    r_cnt[i] <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_levelD <= '0;
            r_press  <= '0;
        end else begin
            r_levelD <= btn_level;
            r_press  <= btn_level & ~r_levelD;
        end
    end

    always_comb begin
        w_ackVec = '0;
        for (int i = 0; i < N_BTN; i++) begin
            w_ackVec[i] = (r_state == OFFER) && evt.evt_ack && (r_evtId == IDX_W'(i));
        end
    end

    // A press always wins over a same-cycle ack so the new press stays queued.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
            overrun <= '0;
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                if (r_press[i]) begin
                    pending[i] <= 1'b1;
                end else if (w_ackVec[i]) begin
                    pending[i] <= 1'b0;
                end

                if (r_press[i] && pending[i] && !w_ackVec[i]) begin
                    overrun[i] <= 1'b1;
                end else if (w_ackVec[i]) begin
                    overrun[i] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        w_found  = 1'b0;
        w_nextId = '0;
        for (int off = 1; off <= N_BTN; off++) begin
            for (int i = 0; i < N_BTN; i++) begin
                if (!w_found && pending[i] && (i == (int'(r_lastGrant) + off) % N_BTN)) begin
                    w_found  = 1'b1;
                    w_nextId = IDX_W'(i);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_valid     <= 1'b0;
            r_evtId     <= '0;
            r_lastGrant <= IDX_W'(N_BTN - 1);
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_evtId <= w_nextId;
                        r_valid <= 1'b1;
                        r_state <= OFFER;
                    end
                end
                OFFER: begin
                    if (evt.evt_ack) begin
                        r_lastGrant <= r_evtId;
                        r_valid     <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign evt.evt_valid = r_valid;
    assign evt.evt_id    = r_evtId;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Scoreboard bench: stimulus pushes the round-robin order of each press burst,
// a separate monitor compares every offered event against the queue.
module tb_button_event_arbiter;

    localparam int N = 5;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] btnRaw = '0;
    logic [4:0] btnLevel;
    logic [4:0] pending;
    logic [4:0] overrun;

    int checks = 0;
    int errors = 0;
    int sb[$];
    int modelLast = N - 1;

    button_event_arbiter_if #(.IDX_W(3)) evtBus();

    button_event_arbiter #(
        .N_BTN(N),
        .IDX_W(3),
        .DEBOUNCE_CYCLES(D),
        .CNT_W(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn_raw(btnRaw),
        .evt(evtBus),
        .btn_level(btnLevel),
        .pending(pending),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Presses that become pending together are granted in ascending distance from the last grant.
    function automatic void pushOrder(input logic [4:0] set);
        int base;
        int idx;
        base = modelLast;
        for (int off = 1; off <= N; off++) begin
            idx = (base + off) % N;
            if (((set >> idx) & 5'd1) != 5'd0) begin
                sb.push_back(idx);
                modelLast = idx;
            end
        end
    endfunction

    task automatic applyStimulus(input logic [4:0] raw, input int cycles);
        btnRaw = raw;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic doReset();
        reset = 1'b1;
        btnRaw = '0;
        evtBus.evt_ack = 1'b0;
        sb.delete();
        modelLast = N - 1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic drainEvents(input int count);
        int w;
        for (int k = 0; k < count; k++) begin
            w = 0;
            while (!evtBus.evt_valid && w < 60) begin
                @(negedge clk);
                w++;
            end
            if (!evtBus.evt_valid) begin
                checkOutput("wait_valid", 0, 1);
                return;
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            evtBus.evt_ack = 1'b1;
            @(negedge clk);
            evtBus.evt_ack = 1'b0;
        end
    endtask

    task automatic runBurst(input logic [4:0] set, input bit bounce);
        pushOrder(set);
        if (bounce) begin
            repeat ($urandom_range(1, 3)) begin
                applyStimulus(set, $urandom_range(1, 3));
                applyStimulus('0, $urandom_range(1, 2));
            end
        end
        applyStimulus(set, 14);
        if (bounce) begin
            applyStimulus('0, $urandom_range(1, 3));
            applyStimulus(set, $urandom_range(1, 2));
        end
        applyStimulus('0, 14);
        drainEvents($countones(set));
        checkOutput("burst_pending", int'(pending), 0);
        checkOutput("burst_overrun", int'(overrun), 0);
        checkOutput("burst_level", int'(btnLevel), 0);
    endtask

    task automatic watchIdle(input int cycles, output int seenValid, output int seenLevel);
        seenValid = 0;
        seenLevel = 0;
        repeat (cycles) begin
            @(negedge clk);
            seenValid |= int'(evtBus.evt_valid);
            seenLevel |= int'(btnLevel);
        end
    endtask

    // Monitor: compares each new offer with the scoreboard, checks hold-until-ack and drop-after-ack.
    initial begin
        logic       prevValid;
        logic       prevAck;
        logic [2:0] prevId;
        prevValid = 1'b0;
        prevAck   = 1'b0;
        prevId    = '0;
        forever begin
            @(negedge clk);
            #1;
            if (reset) begin
                prevValid = 1'b0;
                prevAck   = 1'b0;
                continue;
            end
            if (prevValid && !prevAck) begin
                checkOutput("hold_valid", int'(evtBus.evt_valid), 1);
                checkOutput("hold_id", int'(evtBus.evt_id), int'(prevId));
            end else begin
                if (prevValid && prevAck) begin
                    checkOutput("drop_after_ack", int'(evtBus.evt_valid), 0);
                end
                if (evtBus.evt_valid) begin
                    if (sb.size() == 0) begin
                        checkOutput("unexpected_evt_id", int'(evtBus.evt_id), -1);
                    end else begin
                        checkOutput("evt_id", int'(evtBus.evt_id), sb[0]);
                    end
                    checkOutput("evt_id_range", int'(evtBus.evt_id < 3'd5), 1);
                end
            end
            if (evtBus.evt_valid && evtBus.evt_ack && sb.size() > 0) begin
                void'(sb.pop_front());
            end
            prevValid = evtBus.evt_valid;
            prevAck   = evtBus.evt_ack;
            prevId    = evtBus.evt_id;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int seenValid;
        int seenLevel;
        evtBus.evt_ack = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        checkOutput("rst_valid", int'(evtBus.evt_valid), 0);
        checkOutput("rst_level", int'(btnLevel), 0);
        checkOutput("rst_pending", int'(pending), 0);

        // Asynchronous reset in the middle of an offer
        pushOrder(5'b00001);
        applyStimulus(5'b00001, 12);
        checkOutput("t1_pre_valid", int'(evtBus.evt_valid), 1);
        #3 reset = 1'b1;
        #1;
        checkOutput("t1_valid", int'(evtBus.evt_valid), 0);
        checkOutput("t1_id", int'(evtBus.evt_id), 0);
        checkOutput("t1_level", int'(btnLevel), 0);
        checkOutput("t1_pending", int'(pending), 0);
        checkOutput("t1_overrun", int'(overrun), 0);
        sb.delete();
        modelLast = N - 1;
        btnRaw = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        applyStimulus('0, 4);

        // Single press latency: valid exactly at edge D+4
        pushOrder(5'b00100);
        btnRaw = 5'b00100;
        for (int e = 0; e <= 8; e++) begin
            @(posedge clk);
            #1;
            if (e == 7) begin
                checkOutput("t2_valid_early", int'(evtBus.evt_valid), 0);
            end
        end
        checkOutput("t2_valid", int'(evtBus.evt_valid), 1);
        checkOutput("t2_id", int'(evtBus.evt_id), 2);
        repeat (3) @(posedge clk);
        @(negedge clk);
        applyStimulus('0, 12);
        evtBus.evt_ack = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("t2_valid_after_ack", int'(evtBus.evt_valid), 0);
        checkOutput("t2_pending", int'(pending), 0);
        @(negedge clk);
        evtBus.evt_ack = 1'b0;
        applyStimulus('0, 6);

        // Glitch shorter than the debounce window
        applyStimulus(5'b00010, 3);
        btnRaw = '0;
        watchIdle(15, seenValid, seenLevel);
        checkOutput("t3_level", seenLevel, 0);
        checkOutput("t3_valid", seenValid, 0);
        checkOutput("t3_pending", int'(pending), 0);

        // Round-robin from a fresh reset
        doReset();
        runBurst(5'b10011, 1'b0);
        runBurst(5'b00011, 1'b0);

        // Second press while the first is still pending merges into overrun
        pushOrder(5'b01000);
        applyStimulus(5'b01000, 6);
        applyStimulus('0, 6);
        applyStimulus(5'b01000, 6);
        applyStimulus('0, 14);
        checkOutput("t5_valid", int'(evtBus.evt_valid), 1);
        checkOutput("t5_id", int'(evtBus.evt_id), 3);
        checkOutput("t5_pending", int'(pending), 8);
        checkOutput("t5_overrun", int'(overrun), 8);
        evtBus.evt_ack = 1'b1;
        @(negedge clk);
        evtBus.evt_ack = 1'b0;
        checkOutput("t5_pending_ack", int'(pending), 0);
        checkOutput("t5_overrun_ack", int'(overrun), 0);
        watchIdle(15, seenValid, seenLevel);
        checkOutput("t5_no_second", seenValid, 0);

        // Reset during an offer with two presses queued
        pushOrder(5'b10010);
        applyStimulus(5'b10010, 12);
        checkOutput("t6_pre_pending", int'(pending), 5'b10010);
        checkOutput("t6_pre_valid", int'(evtBus.evt_valid), 1);
        btnRaw = '0;
        #3 reset = 1'b1;
        #1;
        checkOutput("t6_valid", int'(evtBus.evt_valid), 0);
        checkOutput("t6_pending", int'(pending), 0);
        checkOutput("t6_level", int'(btnLevel), 0);
        sb.delete();
        modelLast = N - 1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        watchIdle(20, seenValid, seenLevel);
        checkOutput("t6_no_event", seenValid, 0);

        // Randomised bursts with contact bounce
        for (int b = 0; b < 8; b++) begin
            logic [4:0] s;
            s = 5'($urandom_range(1, 31));
            runBurst(s, 1'b1);
        end

        checkOutput("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
